// File: rtl/gauss_batch_sequencer.sv
// rtl/gauss_batch_sequencer.sv - runs the Gaussian generator for N accepted samples and buffers them in a FIFO
// Optional: define GAUSS_SEQ_CONTINUOUS_EN to add cont_mode (run until abort/error, ignore batch_len).
module gauss_batch_sequencer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 16,
  parameter int MAX_REJ = 255
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [CNT_W-1:0]  batch_len,
  input  logic              abort,
`ifdef GAUSS_SEQ_CONTINUOUS_EN
  input  logic              cont_mode,
`endif
  output logic              gen_run,
  input  logic [DATA_W-1:0] gen_sample,
  input  logic              gen_strobe,
  input  logic              gen_invalid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic [CNT_W-1:0]  rej_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] MAX_REJ_C = CNT_W'(MAX_REJ);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [AW:0]      PTR_ONE   = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              accept;
  logic              reject;
  logic              start_ok;
  logic              cont_in;
  logic              cont_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  consec;
  logic [CNT_W-1:0]  acc_inc;
  logic [CNT_W-1:0]  rej_inc;
  logic [CNT_W-1:0]  consec_inc;

`ifdef GAUSS_SEQ_CONTINUOUS_EN
  assign cont_in = cont_mode;
`else
  assign cont_in = 1'b0;
`endif

  // Extra pointer bit tells a full FIFO (MSBs differ) from an empty one.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign out_valid  = !fifo_empty;
  assign out_data   = mem[rd_ptr[AW-1:0]];

  assign gen_run  = (state == S_RUN) && !fifo_full && (cont_q || (acc_cnt < len_q));
  assign accept   = gen_run && gen_strobe && !gen_invalid;
  assign reject   = gen_run && gen_strobe && gen_invalid;
  assign push     = accept;
  assign pop      = out_valid && out_ready;
  assign start_ok = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

  assign acc_inc    = acc_cnt + CNT_ONE;
  assign rej_inc    = (&rej_cnt) ? rej_cnt : (rej_cnt + CNT_ONE);
  assign consec_inc = consec + CNT_ONE;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= gen_sample;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      acc_cnt <= '0;
      rej_cnt <= '0;
      consec  <= '0;
      len_q   <= '0;
      cont_q  <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else if (start_ok) begin
      acc_cnt <= '0;
      rej_cnt <= '0;
      consec  <= '0;
      len_q   <= batch_len;
      cont_q  <= cont_in;
      error   <= 1'b0;
      if (cont_in || (batch_len != '0)) begin
        state <= S_RUN;
        busy  <= 1'b1;
        done  <= 1'b0;
      end else begin
        state <= S_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (accept) begin
            acc_cnt <= acc_inc;
            consec  <= '0;
            if (!cont_q && (acc_inc == len_q)) begin
              state <= S_DRAIN;
            end
          end else if (reject) begin
            rej_cnt <= rej_inc;
            consec  <= consec_inc;
            if (consec_inc == MAX_REJ_C) begin
              state <= S_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (fifo_empty) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gauss_batch_sequencer.md
Name: gauss_batch_sequencer

Overview:
- Sequences the Gaussian random-number generator (uniform LFSR plus rejection stage) to deliver exactly N accepted samples per batch to the host interface.
- Gates the generator run enable and silently discards rejected attempts.
- Buffers accepted samples in a small FIFO behind a ready/valid port, and reports counts, completion and a stuck-rejection error.
- Sits between the host-interface register block and the generator.

Parameters:
- DATA_W, 32, width of one Gaussian sample.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the batch length and statistic counters.
- MAX_REJ, 255, consecutive-rejection limit that triggers ERROR.

Ports:
- clk  in  1  single clock, rising edge.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a batch; ignored unless state is IDLE, DONE or ERROR.
- batch_len  in  CNT_W  number of accepted samples requested; latched on the start cycle.
- abort  in  1  returns the block to IDLE from any state.
- gen_run  out  1  run enable to the generator (its control input).
- gen_sample  in  DATA_W  generator output sample.
- gen_strobe  in  1  generator produced an attempt this cycle; honoured only when gen_run=1 in the same cycle.
- gen_invalid  in  1  attempt was rejected; qualified by gen_strobe.
- out_data  out  DATA_W  FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  host consumes the head when out_valid&out_ready.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- acc_cnt  out  CNT_W  accepted samples in the current/last batch.
- rej_cnt  out  CNT_W  total rejections in the current/last batch; saturates at all-ones.

Behaviour:
- Reset values:
  - State IDLE.
  - FIFO empty.
  - All outputs 0: gen_run, out_valid, busy, done, error, acc_cnt, rej_cnt, and out_data=0.
- States:
  - IDLE --start, batch_len>0--> RUN.
  - IDLE --start, batch_len=0--> DONE.
  - RUN --acc_cnt reaches batch_len--> DRAIN.
  - RUN --consecutive rejections reach MAX_REJ--> ERROR.
  - DRAIN --FIFO empty--> DONE.
  - DONE/ERROR --start--> as from IDLE.
  - Any state --abort--> IDLE.
- Start action: clears acc_cnt, rej_cnt and the consecutive-reject counter, and latches batch_len.
- gen_run is combinational: (state==RUN) & !fifo_full & (acc_cnt<batch_len). It is therefore 0 in every cycle the FIFO is full.
- Accept: gen_run & gen_strobe & !gen_invalid.
  - Pushes gen_sample into the FIFO.
  - acc_cnt+1.
  - Consecutive-reject counter cleared.
- Reject: gen_run & gen_strobe & gen_invalid.
  - Sample dropped.
  - rej_cnt+1 (saturating).
  - Consecutive-reject counter +1.
- Strobes while gen_run=0 are ignored entirely and counted nowhere.
- FIFO timing:
  - Registered output; a pushed sample is visible on out_data/out_valid the cycle after the push.
  - Push and pop in the same cycle are both allowed; the count is unchanged.
  - Pop when empty has no effect.
  - Read and write pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.
- ERROR:
  - gen_run stays 0.
  - FIFO contents remain drainable through out_valid/out_ready.
  - error stays high until start or abort.
- DONE: done stays high until the next start or abort; counters hold their values.
- Abort:
  - Flushes the FIFO; out_valid=0 the next cycle.
  - Counters hold their values; done and error clear.
  - If abort and start occur in the same cycle, abort wins.
- start while busy is ignored, and batch_len is not relatched.
- Mid-operation reset returns everything to the reset values.

Optional Feature:
- Macro: GAUSS_SEQ_CONTINUOUS_EN.
- When defined:
  - Adds input port cont_mode (1 bit), latched on start.
  - If cont_mode=1, batch_len is ignored: RUN never moves to DRAIN, and acc_cnt wraps modulo 2^CNT_W.
  - The block runs until abort or ERROR.
- When undefined: the port is absent and operation is batch-only as described above.

Test Plan:
- Basic batch: batch_len=4, generator strobes every cycle with gen_invalid=0 and samples 0x11..0x14, out_ready=1.
  - Expected: four pops in order 0x11..0x14; acc_cnt=4, rej_cnt=0; done=1 once the FIFO is empty; gen_run=0 after the 4th accept.
- Rejection filtering: batch_len=3, invalid pattern 0,1,1,0,1,0 with samples A..F.
  - Expected: outputs A,D,F; rej_cnt=3; done=1.
- Backpressure: DEPTH=8, batch_len=12, out_ready=0.
  - Expected: gen_run drops the cycle after the 8th push; no strobe is accepted while full.
  - Then out_ready=1: all 12 samples arrive in order with none lost or duplicated.
- Stuck rejection: gen_invalid=1 constantly.
  - Expected: ERROR after exactly 255 rejections; error=1, gen_run=0, rej_cnt=255.
  - A following start clears error and re-enters RUN.
- Abort and edges:
  - batch_len=0 start → done=1 next cycle, no gen_run pulse.
  - abort during RUN with 3 entries buffered → out_valid=0 next cycle, state IDLE, acc_cnt holds 3.
  - start while busy → ignored.
